pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline stage register replacing per-stage hand-written registers (MEM/WB first).
//  Full-throughput valid/ready stage with 2-entry skid buffer: ts_ready is registered, breaking the
//  combinational ready chain between stages. Carries an opaque DATA_W-bit payload; supports stall and flush.
// PARAMETERS
//  DATA_W     102            payload width (default = pc32+inst32+rw_data32+rw_addr5+rw_en1)
//  RESET_VAL  '0             payload value after reset/flush when CLR_DATA=1
//  CLR_DATA   1              1: flush also loads RESET_VAL into payload regs; 0: only valid bits cleared
//  CNT_W      32             perf counter width (used only with PIPE_STAGE_PERF_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  ls_valid     in   1       last stage valid
//  ts_ready     out  1       this stage ready (registered)
//  in_data      in   DATA_W  payload from last stage
//  ts_valid     out  1       this stage valid to next stage
//  ns_ready     in   1       next stage ready
//  out_data     out  DATA_W  payload to next stage
//  stall        in   1       hazard stall: blocks output transfer
//  flush        in   1       synchronous flush: discard all held entries
//  stall_cnt    out  CNT_W   [PIPE_STAGE_PERF_EN only] cycles holding valid data but not transferring
//  bubble_cnt   out  CNT_W   [PIPE_STAGE_PERF_EN only] cycles with no valid data held
// BEHAVIOUR
//  - Regs: main (m_vld, m_data -> out_data), skid (s_vld, s_data). ts_ready = !s_vld (flop-derived).
//  - acc = ls_valid && ts_ready; fire = ts_valid && ns_ready; ts_valid = m_vld && !stall.
//  - Reset (async): m_vld=s_vld=0, m_data=s_data=RESET_VAL; ts_valid=0, ts_ready=1, out_data=RESET_VAL, counters 0.
//  - Priority per edge: rst > flush > normal. flush: m_vld,s_vld<=0 (payload<=RESET_VAL if CLR_DATA);
//    input accepted in flush cycle is dropped; ts_ready=1 next cycle.
//  - Normal update (FIFO order preserved, no loss, no duplication):
//    !m_vld & acc            -> main<=in, m_vld=1
//    m_vld & fire & !s_vld   -> main<=in if acc, else m_vld<=0
//    m_vld & !fire & acc     -> skid<=in, s_vld=1 (ts_ready low next cycle)
//    m_vld & fire & s_vld    -> main<=skid, s_vld<=0 (ts_ready high next cycle; acc impossible this cycle)
//    otherwise hold all regs.
//  - Latency 1 cycle (in_data at edge N visible on out_data after edge N). Throughput 1/cycle sustained.
//  - stall: output held, ts_valid forced 0; input still accepted into free slot (max 2 held); hold data unchanged.
//  - Simultaneous stall & flush: flush wins. ns_ready ignored when ts_valid=0.
//  - out_data stable while ts_valid && !ns_ready (and while stall).
// CONFIGURATION
//  - `PIPE_STAGE_PERF_EN defined: stall_cnt += 1 when m_vld && !fire; bubble_cnt += 1 when !m_vld;
//    both saturate at all-ones, cleared only by rst (not flush). Ports present.
//  - Undefined: counter ports and logic absent; datapath identical.
// STRUCTURE
//  - Package pipe_pkg: CNT_W default, mem_wb_t packed struct (pc, inst, rw_data, rw_addr, rw_en) with
//    $bits(mem_wb_t)=102, MEM_WB_RESET constant (ADDR/DATA/REG_ADDR invalid, EN invalid).
//  - Sub-module pipe_perf_cnt (saturating counter pair), instantiated only under PIPE_STAGE_PERF_EN.
//  - MEM/WB instance: DATA_W=$bits(mem_wb_t), RESET_VAL=MEM_WB_RESET.
// TESTING
//  1. Stream: ls_valid=1, ns_ready=1, in_data=1,2,3... -> out_data 1,2,3 one cycle later, ts_ready stays 1.
//  2. Backpressure: ns_ready=0 after D=0xA accepted, send 0xB -> skid holds 0xB, ts_ready=0 next cycle;
//     ns_ready=1 -> out 0xA then 0xB, ts_ready=1, no loss.
//  3. stall=1 for 3 cycles with main=0x5 -> ts_valid=0, out_data=0x5 held; release -> 0x5 transfers once.
//  4. flush with both entries full and ls_valid=1 -> next cycle ts_valid=0, ts_ready=1, out_data=RESET_VAL.
//  5. rst asserted mid-stream off-edge -> ts_valid=0 immediately, no clk needed; resumes cleanly after.
//  6. PERF_EN, CNT_W=4: 20 cycles backpressure with data held -> stall_cnt=15 (saturated); 3 idle -> bubble_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: perf counter width default and the MEM/WB payload layout.
package pipe_pkg;

  localparam int PIPE_CNT_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rw_data;
    logic [4:0]  rw_addr;
    logic        rw_en;
  } mem_wb_t;

  // Poisoned address/data patterns so a flushed slot is obvious in waves; rw_en=0 makes it a no-op.
  localparam mem_wb_t MEM_WB_RESET = '{
    pc:      32'hFFFF_FFFF,
    inst:    32'h0000_0013,
    rw_data: 32'hDEAD_BEEF,
    rw_addr: 5'd0,
    rw_en:   1'b0
  };

endpackage

// File: rtl/pipe_perf_cnt.sv
// Array of N saturating event counters; only cleared by the asynchronous reset.
module pipe_perf_cnt import pipe_pkg::*; #(
  parameter int CNT_W = PIPE_CNT_W,
  parameter int N     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              inc,
  output logic [N-1:0][CNT_W-1:0]   cnt
);

  for (genvar i = 0; i < N; i++) begin : g_cnt
    logic [CNT_W-1:0] c;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                        c <= '0;
      else if (inc[i] && (c != '1))   c <= c + 1'b1;
    end
    assign cnt[i] = c;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer so ts_ready comes straight from a flop.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int                DATA_W    = 102,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                CLR_DATA  = 1'b1,
  parameter int                CNT_W     = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  output logic              ts_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ts_valid,
  input  logic              ns_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              m_vld, s_vld;
  logic [DATA_W-1:0] m_data, s_data;
  logic              acc, fire;

  assign ts_ready = !s_vld;
  assign ts_valid = m_vld && !stall;
  assign out_data = m_data;
  assign acc      = ls_valid && ts_ready;
  assign fire     = ts_valid && ns_ready;

  // Skid is only ever occupied while main is, so main always holds the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      m_data <= RESET_VAL;
      s_data <= RESET_VAL;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      if (CLR_DATA) begin
        m_data <= RESET_VAL;
        s_data <= RESET_VAL;
      end
    end else if (!m_vld) begin
      if (acc) begin
        m_data <= in_data;
        m_vld  <= 1'b1;
      end
    end else if (fire) begin
      if (s_vld) begin
        m_data <= s_data;
        s_vld  <= 1'b0;
      end else if (acc) begin
        m_data <= in_data;
      end else begin
        m_vld  <= 1'b0;
      end
    end else if (acc) begin
      s_data <= in_data;
      s_vld  <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [1:0][CNT_W-1:0] cnt;

  pipe_perf_cnt #(.CNT_W(CNT_W), .N(2)) u_perf (
    .clk (clk),
    .rst (rst),
    .inc ({!m_vld, m_vld && !fire}),
    .cnt (cnt)
  );

  assign stall_cnt  = cnt[0];
  assign bubble_cnt = cnt[1];
`endif

endmodule
